// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- parametrised UART receiver with 3-sample majority voting,
// optional parity, one or two stop bits and a one-entry output register.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 8)
//   DATA_BITS     data bits per frame (5..9), LSB first on the line
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   rx           asynchronous serial input, idle high
//   rx_data      received word, stable while rx_valid is high
//   rx_valid     output register holds an unconsumed word
//   rx_ready     consumer accepts the word when rx_valid & rx_ready
//   parity_err   parity mismatch for the held word (qualified by rx_valid)
//   frame_err    a stop bit was sampled low for the held word (qualified by rx_valid)
//   overrun_err  one-cycle pulse when a completed frame is discarded
//   busy         receiver FSM is not IDLE
//   fsm_state    current FSM state, for observation only
//
// Handshake: a word transfers on every clock edge where rx_valid and
// rx_ready are both high. rx_valid stays high, and rx_data/parity_err/
// frame_err stay stable, until that transfer. A frame completing while the
// held word is not being transferred is dropped and overrun_err pulses.
// rx_ready only feeds registers, never an output directly.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy,
  output logic [2:0]           fsm_state
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  // The baud counter reads 0 on each bit boundary (t0 + k*CLKS_PER_BIT), so
  // the vote for sample point t0 + H + k*CLKS_PER_BIT is taken one cycle
  // later, when the counter reads H+1.
  localparam logic [CW-1:0] CNT_DECIDE = CW'(H + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam bit            HAS_PAR    = (PARITY != 0);
  localparam bit            ODD_PAR    = (PARITY == 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic [1:0]           sync;      // sync[1] is the synchronised line (rxs)
  logic [1:0]           hist;      // hist[0] = rxs one cycle ago, hist[1] = two ago
  logic                 rxs;
  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad;
  logic                 frame_bad;
  logic                 start_edge;
  logic                 tick;
  logic                 vote;
  logic                 complete;

  assign rxs        = sync[1];
  assign start_edge = (state == ST_IDLE) && !rxs && hist[0];
  assign tick       = (state != ST_IDLE) && (cnt == CNT_DECIDE);
  // Majority of rxs at sample point -1, sample point and sample point +1.
  assign vote       = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      hist <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
      hist <= {hist[0], rxs};
    end
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    case (state)
      ST_IDLE:  if (start_edge) state_nxt = ST_START;
      ST_START: if (tick) state_nxt = vote ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && (bit_cnt == BIT_LAST)) state_nxt = HAS_PAR ? ST_PAR : ST_STOP;
      ST_PAR:   if (tick) state_nxt = ST_STOP;
      ST_STOP: begin
        if (tick && (bit_cnt == STOP_LAST)) begin
          state_nxt = ST_IDLE;
          complete  = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  // Baud counter: loaded with 1 on the edge-detect cycle so it reads m mod
  // CLKS_PER_BIT at cycle t0+m; held at 0 whenever the FSM is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_nxt == ST_IDLE) begin
      cnt <= '0;
    end else if (state == ST_IDLE) begin
      cnt <= CW'(1);
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Bit counter indexes data bits in DATA and stop bits in STOP; it returns
  // to 0 on leaving either state.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (tick) begin
      if (state == ST_DATA) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end else if (state == ST_STOP) begin
        bit_cnt <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      par_bad   <= 1'b0;
      frame_bad <= 1'b0;
    end else if (start_edge) begin
      par_bad   <= 1'b0;
      frame_bad <= 1'b0;
    end else if (tick) begin
      case (state)
        // LSB arrives first, so shifting right leaves it in bit 0.
        ST_DATA: shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
        // Odd parity wants data^p = 1, even wants 0.
        ST_PAR:  par_bad   <= (^shift_reg) ^ vote ^ ODD_PAR;
        ST_STOP: if (!vote) frame_bad <= 1'b1;
        default: ;
      endcase
    end
  end

  // Output register. The last stop vote is folded in directly because
  // frame_bad only reflects earlier stop bits at completion time.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          rx_valid   <= 1'b1;
          parity_err <= par_bad;
          frame_err  <= frame_bad | ~vote;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the next generation of `uart_rx`. It adds configurable data width, optional parity, and one or two stop bits. Each bit is decided by a 3-sample majority vote. Parity, framing and overrun errors are reported, and a one-entry output register uses a valid/ready handshake. It sits on the serial input pin and feeds a byte-oriented consumer, such as a FIFO or register file, in the same clock domain.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): clock cycles per bit. Legal range is ≥ 8.
- `DATA_BITS`, default 8: data bits per frame. Legal values are 5–9. Sent LSB first.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values are 1 and 2.

- `clk`  in  1: system clock. Single clock domain.
- `reset`  in  1: synchronous reset, active-high.
- `rx`  in  1: asynchronous serial input. Idle is high.
- `rx_data`  out  DATA_BITS: received word, stable while `rx_valid`=1.
- `rx_valid`  out  1: output register holds an unconsumed word.
- `rx_ready`  in  1: consumer accepts the word when `rx_valid`&`rx_ready`.
- `parity_err`  out  1: parity mismatch for the held word. Qualified by `rx_valid`. 0 when PARITY=0.
- `frame_err`  out  1: a stop bit was sampled low for the held word. Qualified by `rx_valid`.
- `overrun_err`  out  1: one-cycle pulse when a frame is lost.
- `busy`  out  1: FSM is not IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. `rxs` is the synchroniser output.
- The start edge is `rxs`=0 while the previous `rxs`=1, detected in IDLE. A low level alone does not count, so a line held low after reset is ignored until it returns high.
- Definitions:
  - H = CLKS_PER_BIT/2 (floor).
  - P = 1 if PARITY≠0, else 0.
  - N = 1 + DATA_BITS + P + STOP_BITS.
- Sample point k (k=0 is the start bit) is cycle t0 + H + k·CLKS_PER_BIT, where t0 is the edge-detect cycle.
- The bit value is the majority of `rxs` at the sample point −1, the sample point, and the sample point +1. It is decided at sample point +1.
- FSM states: IDLE → START → DATA → (PARITY if P) → STOP → IDLE.
  - START: if the vote is 1, the edge is a glitch. Return to IDLE with no outputs and no errors.
  - DATA: shift DATA_BITS votes into a shift register, LSB first. A bit counter counts 0..DATA_BITS-1.
  - PARITY: compare the vote with the XOR of the data. Odd parity requires data^p = 1. Even parity requires data^p = 0.
  - STOP: take STOP_BITS votes. If any vote is 0, set frame_err. Enter IDLE on the cycle after the last stop decision. The next start edge is accepted from that cycle onward.
- Completion happens on the cycle after the last stop decision:
  - If the output register is empty, or it is being accepted this cycle (`rx_valid`&`rx_ready`): load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid`.
  - Otherwise: discard the new frame, keep the old word and flags, and pulse `overrun_err` for 1 cycle.
- Frames with errors are still delivered, with their flags set.
- `rx_valid` clears on the cycle after a handshake, unless a completion loads a new word in that same cycle.
- The baud counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. The bit counter never exceeds DATA_BITS-1.

## Timing
- Reset values, one cycle after `reset`=1:
  - `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0, `busy`=0.
  - FSM = IDLE, counters = 0, synchroniser = 1,1.
- Reset mid-frame drops the frame and clears a held word. Reset has priority over every other event.
- Latency from an `rx` falling edge to the start edge detect (t0) is 2 cycles.
- `rx_valid` rises at cycle t0 + H + (N−1)·CLKS_PER_BIT + 2.
  - Example: CLKS_PER_BIT=16, 8N1 gives t0+154.
- `busy` rises at t0+1. It falls when the FSM re-enters IDLE, which is either the completion cycle or the START glitch-reject cycle.
- Back-to-back frames with no idle gap must be received without loss.
- All outputs are registered. `rx_ready` has no combinational path to any output.

## Test plan
- **8N1 basic.** Set CLKS_PER_BIT=16, keep `rx_ready`=1, drive 0xA5 via the bench TX model. Expect `rx_data`=0xA5 and `rx_valid` high at t0+154, with `parity_err`=0 and `frame_err`=0.
- **Parity and 2 stop bits.** Set DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x55. Expect `rx_data`=0x55 with `parity_err`=0. Resend with the parity bit flipped. Expect 0x55 with `parity_err`=1.
- **Framing error and glitch.** Send 0x3C with the stop bit forced low. Expect 0x3C with `frame_err`=1. Then send a 3-cycle low pulse. Expect `busy` to rise and fall, no `rx_valid`, and no errors.
- **Overrun.** Hold `rx_ready`=0 and send 0x11 then 0x22 back-to-back. Expect `rx_data` to stay 0x11 and a single `overrun_err` pulse. Then assert `rx_ready`. Expect `rx_valid` to fall the next cycle.
- **Accept on completion cycle.** With 0x11 held, assert `rx_ready` exactly on the completion cycle of 0x22. Expect `rx_data`=0x22, `rx_valid` to stay 1, and no overrun.
- **Reset mid-frame.** Assert `reset` during data bit 4 of 0xF0. Expect all outputs 0 on the next cycle, no stale word, and the following frame 0x81 received correctly.
